// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: packs instruction fields into the 16-bit format,
// range-checks immediates and writes words to instruction memory at an auto-incrementing address.
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [2:0]        rn,
    input  logic [2:0]        rd,
    input  logic [2:0]        rm,
    input  logic [1:0]        shift,
    input  logic [15:0]       imm,
    input  logic              clr,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {IDLE, WRITE, ERR, FULL} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic [15:0]       wdata_nxt;
    logic [15:0]       word;
    logic              legal;

    // Field packing; unused fields of a format are simply not routed.
    always_comb begin
        word = {opcode, op, 11'b0};
        case (fmt)
            2'd0:    word[10:0] = {rn, rd, shift, rm};
            2'd1:    word[10:0] = {rn, imm[7:0]};
            2'd2:    word[10:0] = {rn, rd, imm[4:0]};
            default: word[10:0] = 11'b0;
        endcase
    end

    // Immediate fits iff all bits above the field's sign bit replicate it.
    always_comb begin
        legal = 1'b1;
        case (fmt)
            2'd1:    legal = (&imm[15:7]) | ~(|imm[15:7]);
            2'd2:    legal = (&imm[15:4]) | ~(|imm[15:4]);
            default: legal = 1'b1;
        endcase
    end

    assign in_ready = (state == IDLE) && !clr;
    assign mem_wr   = (state == WRITE);
    assign err      = (state == ERR);
    assign full     = (state == FULL);

    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_addr;
        count_nxt = count;
        wdata_nxt = mem_wdata;
        case (state)
            IDLE: begin
                if (clr) begin
                    addr_nxt  = BASE;
                    count_nxt = '0;
                end else if (in_valid) begin
                    if (legal) begin
                        wdata_nxt = word;
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            WRITE: begin
                // clr is deliberately not looked at: an issued write always completes.
                if (mem_ack) begin
                    count_nxt = count + 1'b1;
                    if (mem_addr == LAST) begin
                        state_nxt = FULL;
                    end else begin
                        addr_nxt  = mem_addr + 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            ERR: begin
                state_nxt = IDLE;
                if (clr) begin
                    addr_nxt  = BASE;
                    count_nxt = '0;
                end
            end
            FULL: begin
                if (clr) begin
                    addr_nxt  = BASE;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_addr  <= BASE;
            count     <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            mem_addr  <= addr_nxt;
            count     <= count_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: an 8-bit-address instance for encoding and
// handshake scenarios, a 2-bit-address instance for the fill/full behaviour.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = '0;
    logic [2:0]  opcode = '0;
    logic [1:0]  op = '0;
    logic [2:0]  rn = '0;
    logic [2:0]  rd = '0;
    logic [2:0]  rm = '0;
    logic [1:0]  shift = '0;
    logic [15:0] imm = '0;
    logic        clr = 1'b0;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        err;
    logic        full;
    logic [8:0]  count;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic        clr2 = 1'b0;
    logic        mem_wr2;
    logic [1:0]  mem_addr2;
    logic [15:0] mem_wdata2;
    logic        mem_ack2 = 1'b0;
    logic        err2;
    logic        full2;
    logic [2:0]  count2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } exp_t;
    exp_t        q[$];
    logic [7:0]  exp_addr = '0;

    instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm),
        .shift(shift), .imm(imm), .clr(clr), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .err(err), .full(full), .count(count)
    );

    instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .fmt(fmt), .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm),
        .shift(shift), .imm(imm), .clr(clr2), .mem_wr(mem_wr2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_ack(mem_ack2), .err(err2), .full(full2), .count(count2)
    );

    always #5 clk = ~clk;

    // Every completed write (request and ack both high) must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && mem_wr && mem_ack) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: write addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL sb_write: addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [2:0] opc, input logic [1:0] o,
                              input logic [2:0] n, input logic [2:0] d, input logic [2:0] m,
                              input logic [1:0] sh, input logic [15:0] im);
        fmt = f; opcode = opc; op = o; rn = n; rd = d; rm = m; shift = sh; imm = im;
    endtask

    // Present one instruction for a single accept cycle; legal ones are queued for the scoreboard.
    task automatic send(input logic [1:0] f, input logic [2:0] opc, input logic [1:0] o,
                        input logic [2:0] n, input logic [2:0] d, input logic [2:0] m,
                        input logic [1:0] sh, input logic [15:0] im,
                        input logic [15:0] word, input bit legal);
        set_fields(f, opc, o, n, d, m, sh, im);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b, required 1", in_ready);
        end
        if (legal) begin
            q.push_back('{a: exp_addr, d: word});
            exp_addr++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000 ||
            err !== 1'b0 || full !== 1'b0 || count !== 9'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: wr=%b addr=%h wdata=%h err=%b full=%b count=%0d rdy=%b, required 0 0 0 0 0 0 1",
                     mem_wr, mem_addr, mem_wdata, err, full, count, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_addr = '0;
        tick();
    endtask

    task automatic test_imm8();
        mem_ack = 1'b1;
        send(2'd1, 3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'd0, 16'hFFFB, 16'hD1FB, 1'b1);
        checks++;
        if (mem_wr !== 1'b1 || mem_wdata !== 16'hD1FB || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL imm8_req: wr=%b data=%h addr=%h, required 1 d1fb 00", mem_wr, mem_wdata, mem_addr);
        end
        tick();
        checks++;
        if (mem_wr !== 1'b0 || count !== 9'd1 || mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL imm8_done: wr=%b count=%0d addr=%h, required 0 1 01", mem_wr, count, mem_addr);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reg_delayed_ack();
        send(2'd0, 3'b101, 2'b00, 3'd1, 3'd2, 3'd0, 2'b01, 16'h0000, 16'hA148, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_wr !== 1'b1 || mem_wdata !== 16'hA148 || mem_addr !== 8'h01 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reg_hold[%0d]: wr=%b data=%h addr=%h rdy=%b, required 1 a148 01 0",
                         i, mem_wr, mem_wdata, mem_addr, in_ready);
            end
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== 8'h02 || count !== 9'd2) begin
            errors++;
            $display("FAIL reg_done: wr=%b addr=%h count=%0d, required 0 02 2", mem_wr, mem_addr, count);
        end
    endtask

    task automatic check_err(input string name);
        checks++;
        if (err !== 1'b1 || mem_wr !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: err=%b wr=%b rdy=%b, required 1 0 0", name, err, mem_wr, in_ready);
        end
        tick();
        checks++;
        if (err !== 1'b0 || mem_wr !== 1'b0 || count !== 9'd4 || mem_addr !== 8'h04 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after: err=%b wr=%b count=%0d addr=%h rdy=%b, required 0 0 4 04 1",
                     name, err, mem_wr, count, mem_addr, in_ready);
        end
    endtask

    task automatic test_range();
        mem_ack = 1'b1;
        send(2'd2, 3'b011, 2'b00, 3'd3, 3'd4, 3'd0, 2'd0, 16'hFFF0, 16'h6390, 1'b1);
        tick();
        send(2'd1, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h007F, 16'h007F, 1'b1);
        tick();
        checks++;
        if (count !== 9'd4 || mem_addr !== 8'h04) begin
            errors++;
            $display("FAIL range_legal: count=%0d addr=%h, required 4 04", count, mem_addr);
        end
        send(2'd2, 3'b011, 2'b00, 3'd3, 3'd4, 3'd0, 2'd0, 16'h0010, 16'h0000, 1'b0);
        check_err("imm5_16");
        send(2'd1, 3'b011, 2'b00, 3'd3, 3'd0, 3'd0, 2'd0, 16'd200, 16'h0000, 1'b0);
        check_err("imm8_200");
        send(2'd1, 3'b011, 2'b00, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFF7F, 16'h0000, 1'b0);
        check_err("imm8_m129");
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        send(2'd3, 3'b111, 2'b11, 3'd5, 3'd5, 3'd5, 2'd3, 16'hFFFF, 16'hF800, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000 ||
            count !== 9'd0 || err !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: wr=%b addr=%h wdata=%h count=%0d err=%b full=%b, required all 0",
                     mem_wr, mem_addr, mem_wdata, count, err, full);
        end
        q.delete();
        exp_addr = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        send(2'd3, 3'b111, 2'b11, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 16'hF800, 1'b1);
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 16'hF800) begin
            errors++;
            $display("FAIL rst_rewrite: wr=%b addr=%h data=%h, required 1 00 f800", mem_wr, mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_boundary();
        set_fields(2'd0, 3'b001, 2'b01, 3'd1, 3'd1, 3'd1, 2'd1, 16'h0000);
        clr = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: in_ready=%b, required 0", in_ready);
        end
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        exp_addr = '0;
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== 8'h00 || count !== 9'd0) begin
            errors++;
            $display("FAIL clr_valid: wr=%b addr=%h count=%0d, required 0 00 0", mem_wr, mem_addr, count);
        end
        send(2'd0, 3'b010, 2'b01, 3'd7, 3'd6, 3'd5, 2'd2, 16'h0000, 16'h4FD5, 1'b1);
        clr = 1'b1;
        tick();
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL clr_in_write: wr=%b addr=%h, required 1 00", mem_wr, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        clr = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== 8'h01 || count !== 9'd1) begin
            errors++;
            $display("FAIL clr_write_done: wr=%b addr=%h count=%0d, required 0 01 1", mem_wr, mem_addr, count);
        end
    endtask

    task automatic test_full();
        mem_ack2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_fields(2'd3, 3'(i), 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
            in_valid2 = 1'b1;
            tick();
            in_valid2 = 1'b0;
            checks++;
            if (mem_wr2 !== 1'b1 || mem_addr2 !== 2'(i) || mem_wdata2 !== {3'(i), 13'b0}) begin
                errors++;
                $display("FAIL full_wr[%0d]: wr=%b addr=%0d data=%h, required 1 %0d %h",
                         i, mem_wr2, mem_addr2, mem_wdata2, i, {3'(i), 13'b0});
            end
            tick();
        end
        checks++;
        if (full2 !== 1'b1 || count2 !== 3'd4 || mem_addr2 !== 2'd3 || in_ready2 !== 1'b0) begin
            errors++;
            $display("FAIL full_set: full=%b count=%0d addr=%0d rdy=%b, required 1 4 3 0",
                     full2, count2, mem_addr2, in_ready2);
        end
        in_valid2 = 1'b1;
        tick();
        tick();
        in_valid2 = 1'b0;
        checks++;
        if (mem_wr2 !== 1'b0 || count2 !== 3'd4 || full2 !== 1'b1) begin
            errors++;
            $display("FAIL full_ignore: wr=%b count=%0d full=%b, required 0 4 1", mem_wr2, count2, full2);
        end
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        mem_ack2 = 1'b0;
        #1;
        checks++;
        if (full2 !== 1'b0 || mem_addr2 !== 2'd0 || count2 !== 3'd0 || in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL full_clr: full=%b addr=%0d count=%0d rdy=%b, required 0 0 0 1",
                     full2, mem_addr2, count2, in_ready2);
        end
    endtask

    initial begin
        test_reset();
        test_imm8();
        test_reg_delayed_ack();
        test_range();
        test_reset_mid_write();
        test_boundary();
        test_full();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writes outstanding, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Sequential instruction encoder/loader for the 16-bit datapath CPU, i.e. the writer for the instruction decoder's reader. It accepts one instruction as separate fields over a valid/ready handshake. It packs the fields into the 16-bit instruction format, checks that any immediate fits its field, and writes the word to instruction memory at an auto-incrementing address using a write/ack handshake. It sits between the test/boot controller and instruction memory, and fills program memory before the CPU runs.

Parameters:
ADDR_W, 8, instruction memory address width; depth = 2^ADDR_W words
BASE_ADDR, 0, first write address after reset or clr

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  instruction fields valid
in_ready  output  1  block can accept fields this cycle
fmt  input  2  field format: 0=reg (Rn,Rd,shift,Rm), 1=imm8 (Rn,imm8), 2=imm5 (Rn,Rd,imm5), 3=bare (opcode,op only)
opcode  input  3  instruction opcode
op  input  2  op/ALUop field
rn  input  3  Rn register
rd  input  3  Rd register
rm  input  3  Rm register
shift  input  2  shift code
imm  input  16  signed two's-complement immediate value
clr  input  1  synchronous restart of address/count
mem_wr  output  1  memory write request
mem_addr  output  ADDR_W  write address
mem_wdata  output  16  encoded instruction word
mem_ack  input  1  memory accepted write
err  output  1  one-cycle pulse: immediate out of range, instruction dropped
full  output  1  memory filled, no further accepts
count  output  ADDR_W+1  number of words successfully written

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, mem_wr=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, full=0, count=0. A reset during WRITE drops mem_wr immediately and discards the pending word.
- States: IDLE, WRITE, ERR, FULL.
- in_ready = (state==IDLE) && !clr. This is combinational.
- Encoding, fixed bit positions: [15:13]=opcode, [12:11]=op.
  - fmt0: [10:8]=rn, [7:5]=rd, [4:3]=shift, [2:0]=rm.
  - fmt1: [10:8]=rn, [7:0]=imm[7:0].
  - fmt2: [10:8]=rn, [7:5]=rd, [4:0]=imm[4:0].
  - fmt3: [10:0]=0.
  - Fields not used by a format are ignored.
- Range check:
  - fmt1 is legal iff imm[15:7] are all equal (-128..127).
  - fmt2 is legal iff imm[15:4] are all equal (-16..15).
  - fmt0 and fmt3 are always legal.
- IDLE:
  - on in_valid && in_ready with a legal value: register mem_wdata, go to WRITE. mem_wr=1 on the next cycle, so latency from accept to request is 1 cycle.
  - on in_valid && in_ready with an illegal value: go to ERR. err=1 for exactly that one cycle. No write; address and count are unchanged.
- WRITE:
  - mem_wr, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
  - on the ack edge: mem_wr drops to 0 and count increments.
  - if mem_addr was the last address (all ones relative to depth): go to FULL and set full=1; mem_addr stays at the last address.
  - otherwise: mem_addr increments and the next state is IDLE.
  - An ack on the same cycle as the request counts; the minimum WRITE duration is 1 cycle.
- ERR: returns to IDLE unconditionally after one cycle; in_ready=0 during ERR.
- FULL: in_ready=0. Only clr or reset leaves FULL.
- clr:
  - honoured in IDLE, ERR and FULL: mem_addr=BASE_ADDR, count=0, full=0, next state IDLE.
  - ignored in WRITE; the write completes normally.
  - clr and in_valid in the same IDLE cycle: clr wins and the fields are not accepted, because in_ready=0.
- mem_ack outside WRITE is ignored.
- Because in_ready is low in WRITE, ERR and FULL, in_valid is never accepted in those states.
- Upstream must hold the fields stable while in_valid && !in_ready.

Test Plan:
- Reset, then fmt1 opcode=110 op=10 rn=1 imm=16'hFFFB (-5); mem_ack held high -> mem_wr=1 one cycle after accept, mem_wdata=16'hD1FB, mem_addr=0, then count=1 and mem_addr=1.
- fmt0 opcode=101 op=00 rn=1 rd=2 shift=01 rm=0, with mem_ack delayed 3 cycles -> mem_wdata=16'hA148 held with mem_wr=1 for 4 cycles, in_ready=0 throughout, address advances only after ack.
- Range check:
  - fmt2 opcode=011 op=00 rn=3 rd=4 imm=-16 -> 16'h6390 written.
  - Then fmt2 imm=16, and fmt1 imm=200 -> err pulses 1 cycle each, no mem_wr, count and mem_addr unchanged.
- ADDR_W=2: four legal writes -> full=1 after the 4th ack, in_ready=0, a 5th in_valid is ignored; clr -> full=0, mem_addr=0, count=0, in_ready=1.
- Assert reset_n low mid-WRITE (mem_ack low) -> mem_wr=0 immediately and all outputs at reset values; a subsequent write goes to BASE_ADDR.
- Boundary events:
  - clr and in_valid in the same IDLE cycle -> no accept, address restarted.
  - clr during WRITE -> ignored; write completes and the address increments.
